atm_bank_host: RTL and testbench

ATM_BANK_HOST -- requirements
Module: atm_bank_host

---
 rtl/atm_pkg.sv | 41 ++++
 rtl/atm_bank_host_if.sv | 27 ++
 rtl/atm_acc_lookup.sv | 24 ++
 rtl/atm_bank_host.sv | 180 ++++++++++++++++++
 tb/tb_atm_bank_host.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared constants, state encoding, account/PIN table and request payload for the ATM bank host.
package atm_pkg;

  localparam int unsigned ACC_W = 12;
  localparam int unsigned PIN_W = 4;
  localparam int unsigned BAL_W = 11;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned TBL_N = 4;

  localparam logic [OP_W-1:0] OP_AUTH     = 3'd0;
  localparam logic [OP_W-1:0] OP_BALANCE  = 3'd1;
  localparam logic [OP_W-1:0] OP_WITHDRAW = 3'd2;
  localparam logic [OP_W-1:0] OP_TRANSFER = 3'd3;
  localparam logic [OP_W-1:0] OP_LOGOUT   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Entry 0 is the rightmost element of each concatenation.
  localparam logic [TBL_N-1:0][ACC_W-1:0] ACC_TBL = {12'd1234, 12'd4039, 12'd2175, 12'd2749};
  localparam logic [TBL_N-1:0][PIN_W-1:0] PIN_TBL = {4'd6, 4'd9, 4'd3, 4'd6};

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ACC_W-1:0] acc;
    logic [PIN_W-1:0] pin;
    logic [BAL_W-1:0] amount;
  } req_t;

  // A credit fits when the widened sum produces no carry past the balance width.
  function automatic logic credit_fits(input logic [BAL_W-1:0] bal, input logic [BAL_W-1:0] amt);
    logic [BAL_W:0] sum;
    sum = {1'b0, bal} + {1'b0, amt};
    return !sum[BAL_W];
  endfunction

endpackage

// File: rtl/atm_bank_host_if.sv
// Request/response handshake bundle between the ATM controller (master) and the bank host (slave).
interface atm_bank_host_if;
  import atm_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [OP_W-1:0]  req_op;
  logic [ACC_W-1:0] req_acc;
  logic [PIN_W-1:0] req_pin;
  logic [BAL_W-1:0] req_amount;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_error;
  logic [BAL_W-1:0] resp_balance;
  logic             session_active;

  modport master (
    output req_valid, req_op, req_acc, req_pin, req_amount, resp_ready,
    input  req_ready, resp_valid, resp_error, resp_balance, session_active
  );

  modport slave (
    input  req_valid, req_op, req_acc, req_pin, req_amount, resp_ready,
    output req_ready, resp_valid, resp_error, resp_balance, session_active
  );

endinterface

// File: rtl/atm_acc_lookup.sv
// Parallel account-number match against the constant table; lowest matching index wins.
module atm_acc_lookup
  import atm_pkg::*;
#(
  parameter  int unsigned NUM_ACC = 4,
  localparam int unsigned IDX_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic             hit_c,
  output logic [IDX_W-1:0] idx_c
);

  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (!hit_c && (acc_i == ACC_TBL[i])) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/atm_bank_host.sv
// Bank host: accepts one ATM request at a time, looks up the account, executes, and holds the response.
module atm_bank_host
  import atm_pkg::*;
#(
  parameter int unsigned      NUM_ACC  = 4,
  parameter logic [BAL_W-1:0] INIT_BAL = 11'd500,
  parameter int unsigned      MAX_FAIL = 3
) (
  input logic         clk,
  input logic         rst,
  atm_bank_host_if.slave bus
);

  localparam int unsigned IDX_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  state_e state_q, state_d;

  req_t                           req_q, req_d;
  logic                           hit_q, hit_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [NUM_ACC-1:0][BAL_W-1:0]  bal_q, bal_d;
  logic [NUM_ACC-1:0][FAIL_W-1:0] fail_q, fail_d;
  logic [NUM_ACC-1:0]             lock_q, lock_d;
  logic                           sess_q, sess_d;
  logic [IDX_W-1:0]               sess_idx_q, sess_idx_d;
  logic                           req_ready_q, req_ready_d;
  logic                           resp_valid_q, resp_valid_d;
  logic                           resp_error_q, resp_error_d;
  logic [BAL_W-1:0]               resp_balance_q, resp_balance_d;

  logic             lk_hit_c;
  logic [IDX_W-1:0] lk_idx_c;
  logic             accept_c;
  logic             err_c;
  logic [BAL_W-1:0] src_bal_c;
  logic [BAL_W-1:0] dst_bal_c;
  logic [FAIL_W-1:0] fail_inc_c;

  assign accept_c = bus.req_valid & req_ready_q;

  atm_acc_lookup #(.NUM_ACC(NUM_ACC)) u_lookup (
    .acc_i (req_q.acc),
    .hit_c (lk_hit_c),
    .idx_c (lk_idx_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept_c) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_RESP;
      ST_RESP:   if (bus.resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; all commits happen on the EXEC edge only.
  always_comb begin
    req_d          = req_q;
    hit_d          = hit_q;
    idx_d          = idx_q;
    bal_d          = bal_q;
    fail_d         = fail_q;
    lock_d         = lock_q;
    sess_d         = sess_q;
    sess_idx_d     = sess_idx_q;
    resp_error_d   = resp_error_q;
    resp_balance_d = resp_balance_q;
    req_ready_d    = (state_d == ST_IDLE);
    resp_valid_d   = (state_d == ST_RESP);
    err_c          = 1'b0;
    src_bal_c      = bal_q[sess_idx_q];
    dst_bal_c      = bal_q[idx_q];
    fail_inc_c     = FAIL_W'(fail_q[idx_q] + 1'b1);

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          req_d.op     = bus.req_op;
          req_d.acc    = bus.req_acc;
          req_d.pin    = bus.req_pin;
          req_d.amount = bus.req_amount;
        end
      end
      ST_LOOKUP: begin
        hit_d = lk_hit_c;
        idx_d = lk_idx_c;
      end
      ST_EXEC: begin
        case (req_q.op)
          OP_AUTH: begin
            if (!hit_q || lock_q[idx_q] || sess_q) begin
              err_c = 1'b1;
            end else if (req_q.pin != PIN_TBL[idx_q]) begin
              // Wrong PIN is the one error that still updates state.
              err_c          = 1'b1;
              fail_d[idx_q]  = fail_inc_c;
              if (32'(fail_inc_c) >= MAX_FAIL) lock_d[idx_q] = 1'b1;
            end else begin
              fail_d[idx_q] = '0;
              sess_d        = 1'b1;
              sess_idx_d    = idx_q;
            end
          end
          OP_BALANCE: begin
            err_c = !sess_q;
          end
          OP_WITHDRAW: begin
            if (!sess_q || (req_q.amount > src_bal_c)) err_c = 1'b1;
            else bal_d[sess_idx_q] = src_bal_c - req_q.amount;
          end
          OP_TRANSFER: begin
            if (!sess_q || !hit_q || (idx_q == sess_idx_q) ||
                (req_q.amount > src_bal_c) || !credit_fits(dst_bal_c, req_q.amount)) begin
              err_c = 1'b1;
            end else begin
              bal_d[sess_idx_q] = src_bal_c - req_q.amount;
              bal_d[idx_q]      = dst_bal_c + req_q.amount;
            end
          end
          OP_LOGOUT: begin
            if (!sess_q) err_c = 1'b1;
            else sess_d = 1'b0;
          end
          default: err_c = 1'b1;
        endcase
        resp_error_d   = err_c;
        resp_balance_d = sess_d ? bal_d[sess_idx_d] : '0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q          <= '0;
      hit_q          <= 1'b0;
      idx_q          <= '0;
      bal_q          <= {NUM_ACC{INIT_BAL}};
      fail_q         <= '0;
      lock_q         <= '0;
      sess_q         <= 1'b0;
      sess_idx_q     <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_error_q   <= 1'b0;
      resp_balance_q <= '0;
    end else begin
      req_q          <= req_d;
      hit_q          <= hit_d;
      idx_q          <= idx_d;
      bal_q          <= bal_d;
      fail_q         <= fail_d;
      lock_q         <= lock_d;
      sess_q         <= sess_d;
      sess_idx_q     <= sess_idx_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_error_q   <= resp_error_d;
      resp_balance_q <= resp_balance_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.resp_balance   = resp_balance_q;
  assign bus.session_active = sess_q;

endmodule

// File: tb/tb_atm_bank_host.sv
// Scoreboard bench for atm_bank_host: directed scenarios plus random traffic against an account-level model.
module tb_atm_bank_host;
  import atm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_bank_host_if bus();

  atm_bank_host #(.NUM_ACC(4), .INIT_BAL(11'd500), .MAX_FAIL(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit    err;
    int    bal;
    bit    sa;
    int    acc_cyc;
    string name;
  } exp_t;
  exp_t expq[$];

  // Reference model: plain bookkeeping of the four accounts
  int m_acc[4] = '{2749, 2175, 4039, 1234};
  int m_pin[4] = '{6, 3, 9, 6};
  int m_bal[4];
  int m_fail[4];
  bit m_lock[4];
  int m_sess;
  int force_hold = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_bal[i] = 500; m_fail[i] = 0; m_lock[i] = 1'b0;
    end
    m_sess = -1;
  endtask

  function automatic int find(input int a);
    for (int i = 0; i < 4; i++) if (m_acc[i] == a) return i;
    return -1;
  endfunction

  task automatic model_step(input int op, input int acc, input int pin, input int amt, output exp_t e);
    int d;
    bit err;
    d = find(acc);
    err = 1'b0;
    case (op)
      0: begin
        if (d < 0 || m_lock[d] || m_sess >= 0) err = 1'b1;
        else if (pin != m_pin[d]) begin
          err = 1'b1;
          m_fail[d]++;
          if (m_fail[d] >= 3) m_lock[d] = 1'b1;
        end else begin
          m_fail[d] = 0;
          m_sess = d;
        end
      end
      1: err = (m_sess < 0);
      2: begin
        if (m_sess < 0) err = 1'b1;
        else if (amt > m_bal[m_sess]) err = 1'b1;
        else m_bal[m_sess] -= amt;
      end
      3: begin
        if (m_sess < 0 || d < 0) err = 1'b1;
        else if (d == m_sess || amt > m_bal[m_sess] || m_bal[d] + amt > 2047) err = 1'b1;
        else begin
          m_bal[m_sess] -= amt;
          m_bal[d] += amt;
        end
      end
      4: begin
        if (m_sess < 0) err = 1'b1;
        else m_sess = -1;
      end
      default: err = 1'b1;
    endcase
    e.err = err;
    e.bal = (m_sess >= 0) ? m_bal[m_sess] : 0;
    e.sa  = (m_sess >= 0);
  endtask

  task automatic issue(input string name, input int op, input int acc, input int pin,
                       input int amt, input int hold);
    int   waitc;
    exp_t e;
    waitc = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = 3'(op);
    bus.req_acc    = 12'(acc);
    bus.req_pin    = 4'(pin);
    bus.req_amount = 11'(amt);
    while (!bus.req_ready && waitc < 60) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got req_ready 0 expected 1", name);
      bus.req_valid = 1'b0;
      return;
    end
    model_step(op, acc, pin, amt, e);
    e.acc_cyc = cyc;
    e.name    = name;
    expq.push_back(e);
    force_hold = hold;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'($urandom);
    bus.req_acc    = 12'($urandom);
    bus.req_pin    = 4'($urandom);
    bus.req_amount = 11'($urandom);
  endtask

  // Response acceptor: random backpressure, or a forced stall on request
  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (force_hold > 0 && bus.resp_valid) begin
        bus.resp_ready = 1'b0;
        force_hold--;
      end else begin
        bus.resp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops one expectation per response and checks it stays put while stalled
  bit in_resp = 1'b0;
  int h_err, h_bal;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_resp = 1'b0;
      end else if (bus.resp_valid) begin
        check("req_ready_busy", int'(bus.req_ready), 0);
        if (!in_resp) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid 1 expected 0");
          end else begin
            e = expq.pop_front();
            check({e.name, "_err"}, int'(bus.resp_error), int'(e.err));
            check({e.name, "_bal"}, int'(bus.resp_balance), e.bal);
            check({e.name, "_sess"}, int'(bus.session_active), int'(e.sa));
            check({e.name, "_lat"}, cyc - e.acc_cyc, 3);
          end
          h_err   = int'(bus.resp_error);
          h_bal   = int'(bus.resp_balance);
          in_resp = 1'b1;
        end else begin
          check("hold_err", int'(bus.resp_error), h_err);
          check("hold_bal", int'(bus.resp_balance), h_bal);
        end
        if (bus.resp_ready) in_resp = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, int'(bus.req_ready), 1);
    check({tag, "_resp_valid"}, int'(bus.resp_valid), 0);
    check({tag, "_resp_error"}, int'(bus.resp_error), 0);
    check({tag, "_resp_balance"}, int'(bus.resp_balance), 0);
    check({tag, "_session"}, int'(bus.session_active), 0);
  endtask

  initial begin
    int opsel, op, ai, acc, pin, amt, hold, w;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_acc    = '0;
    bus.req_pin    = '0;
    bus.req_amount = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    issue("auth_2749", 0, 2749, 6, 0, 0);
    issue("bal_hold", 1, 0, 0, 0, 5);
    issue("wd200", 2, 0, 0, 200, 0);
    issue("wd301", 2, 0, 0, 301, 0);
    issue("xfer100", 3, 1234, 0, 100, 0);
    issue("logout1", 4, 0, 0, 0, 0);
    issue("auth_1234", 0, 1234, 6, 0, 0);
    issue("logout2", 4, 0, 0, 0, 0);
    issue("auth_2749b", 0, 2749, 6, 0, 0);
    issue("xfer_self", 3, 2749, 0, 10, 0);
    issue("logout3", 4, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) issue("auth_badpin", 0, 2175, 0, 0, 0);
    issue("auth_locked", 0, 2175, 3, 0, 0);
    issue("wd_nosess", 2, 0, 0, 1, 0);
    issue("illegal_nosess", 6, 0, 0, 0, 0);
    issue("logout_nosess", 4, 0, 0, 0, 0);
    issue("auth_miss", 0, 100, 6, 0, 0);
    issue("auth_4039", 0, 4039, 9, 0, 0);
    issue("auth_twice", 0, 2749, 6, 0, 2);
    issue("wd_all", 2, 0, 0, 500, 0);
    issue("wd_zero", 2, 0, 0, 0, 0);
    issue("xfer_empty", 3, 2749, 0, 1, 0);
    issue("xfer_miss", 3, 99, 0, 0, 0);
    issue("illegal_sess", 7, 0, 0, 0, 0);
    issue("logout4", 4, 0, 0, 0, 0);

    // Reset during EXEC of a withdraw: nothing may commit
    issue("auth_pre_rst", 0, 2749, 6, 0, 0);
    issue("wd_rst", 2, 0, 0, 100, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    void'(expq.pop_back());
    model_reset();
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_session", int'(bus.session_active), 0);
    issue("auth_post_rst", 0, 2749, 6, 0, 0);
    issue("bal_post_rst", 1, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      opsel = $urandom_range(0, 15);
      op = (opsel < 3) ? 0 : (opsel < 6) ? 1 : (opsel < 9) ? 2 :
           (opsel < 12) ? 3 : (opsel < 14) ? 4 : $urandom_range(5, 7);
      ai   = $urandom_range(0, 3);
      acc  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4095) : m_acc[ai];
      pin  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : m_pin[ai];
      amt  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 150) : $urandom_range(0, 2047);
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      issue("rand", op, acc, pin, amt, hold);
    end

    w = 0;
    while ((expq.size() != 0 || bus.resp_valid) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
